pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready handshake, flush and an optional
//  2-entry skid buffer, which breaks the combinational ready path between adjacent stages.
//  Carries payload, exception vector and delay-slot flag as one bundle.
//  Instantiated between IF/ID/EXE/MEM/WB; a flushed or empty stage presents all-zero payload (NOP).
// PARAMETERS
//  DATA_W   128  payload width (bits)
//  EXC_W    5    exception vector width
//  SKID     1    0 = single register (in_ready combinational); 1 = 2-entry skid (in_ready registered)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  reset      in   1       synchronous, active-high; clears all state
//  cancel     in   1       flush (exception/eret); clears all entries at next edge
//  in_valid   in   1       upstream stage over, bundle valid
//  in_ready   out  1       this register can accept (upstream allow_in)
//  in_data    in   DATA_W  upstream payload
//  in_exc     in   EXC_W   upstream exception flags
//  in_delay   in   1       upstream instruction sits in a delay slot
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream allow_in
//  out_data   out  DATA_W  head payload; zero when out_valid=0
//  out_exc    out  EXC_W   head exception flags; zero when out_valid=0
//  out_delay  out  1       head delay flag; zero when out_valid=0
//  occupancy  out  2       entries held (0..1 if SKID=0, 0..2 if SKID=1)
// BEHAVIOUR
//  - Reset/cancel: every output and both entries go to 0 next edge; reset > cancel > transfers.
//    A bundle offered in the same cycle as cancel is dropped (in_ready value is irrelevant).
//  - acc = in_valid & in_ready; pop = out_valid & out_ready. Each bundle is accepted exactly once,
//    emitted exactly once, in order. Latency: 1 cycle from acc to out_valid when empty.
//  - Empty entries always hold zeros; out_* are driven from the head entry only.
//  SKID=0: in_ready = ~out_valid | out_ready (combinational).
//    acc -> head <= input; pop & ~acc -> head <= 0 (bubble); else hold.
//  SKID=1: states EMPTY(0), ONE(1), FULL(2); in_ready = (state != FULL), from flops only.
//    EMPTY: acc -> ONE (head <= in).
//    ONE:   acc & pop -> ONE (head <= in); acc & ~pop -> FULL (skid <= in);
//           ~acc & pop -> EMPTY (head <= 0); else hold.
//    FULL:  pop -> ONE (head <= skid, skid <= 0); else hold (in_ready=0, no acc possible).
//  - occupancy = state count; never exceeds 2; no overflow/underflow in any input sequence.
//  - in_valid with in_ready=0: upstream must hold bundle stable; this block does not sample it.
//  - out_ready with out_valid=0: no effect.
// TESTING
//  1 reset: drive reset=1 with in_valid=1, in_data=128'hA5.. -> next edge out_valid=0, out_data=0,
//    occupancy=0, in_ready=1.
//  2 stream, SKID=1: in_valid=1, out_ready=1 every cycle, data 1,2,3,4 -> out_data 1,2,3,4 on
//    cycles 1..4, occupancy stays 1.
//  3 backpressure, SKID=1: send 0x11,0x22 with out_ready=0 -> occupancy 2, in_ready=0, out_data=0x11;
//    raise out_ready -> 0x11 then 0x22 emitted, occupancy 2->1->0, data 0x33 offered meanwhile is not lost.
//  4 flush: occupancy 2 with exc=5'b10000, delay=1; cancel=1 with in_valid=1 -> next edge all
//    outputs 0, occupancy 0; offered bundle dropped.
//  5 SKID=0: out_ready=0, out_valid=1 -> in_ready=0 same cycle; out_ready=1 & in_valid=1 ->
//    head replaced next edge; out_ready=1 & in_valid=0 -> out_data=0 (bubble).
//  6 random: scoreboard in/out over 10k cycles with random valid/ready/cancel for SKID=0,1 ->
//    order preserved, no duplicates, occupancy bounds held, out_*=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and optional 2-entry skid.
// Payload, exception vector and delay-slot flag travel as one bundle; empty entries hold zeros.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 128,
  parameter int EXC_W  = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_delay,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_delay,
  output logic [1:0]        occupancy
);

  localparam int BW = DATA_W + EXC_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Handshake: a bundle moves on a clock edge only when valid and ready are both high
  // in that cycle; valid never waits on ready, and a held bundle must stay stable.
  state_t        state_q, state_d;
  logic [BW-1:0] head_q, head_d;
  logic [BW-1:0] skid_q, skid_d;
  logic [BW-1:0] in_bundle;
  logic          acc, pop;

  assign in_bundle = {in_data, in_exc, in_delay};
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (cancel) begin
      state_d = ST_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else if (SKID == 0) begin
      skid_d = '0;
      if (acc) begin
        state_d = ST_ONE;
        head_d  = in_bundle;
      end else if (pop) begin
        state_d = ST_EMPTY;
        head_d  = '0;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            head_d  = in_bundle;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            head_d = in_bundle;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_d  = in_bundle;
          end else if (pop) begin
            state_d = ST_EMPTY;
            head_d  = '0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // The skid variant derives in_ready from flops only, cutting the ready path to downstream.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    occupancy = state_q;
    {out_data, out_exc, out_delay} = head_q;
    if (SKID == 0) begin
      in_ready = ~out_valid | out_ready;
    end else begin
      in_ready = (state_q != ST_FULL);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: one SKID=0 and one SKID=1 instance checked against
// a bounded-queue reference model, with directed cases followed by random traffic.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 128;
  localparam int EXC_W  = 5;
  localparam int BW     = DATA_W + EXC_W + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // index 0: SKID=0 instance, index 1: SKID=1 instance
  logic              iv   [2];
  logic              ird  [2];
  logic [DATA_W-1:0] idat [2];
  logic [EXC_W-1:0]  iexc [2];
  logic              idl  [2];
  logic              ov   [2];
  logic              ordy [2];
  logic [DATA_W-1:0] odat [2];
  logic [EXC_W-1:0]  oexc [2];
  logic              odl  [2];
  logic [1:0]        occ  [2];
  logic              cnc  [2];
  logic              free_q [2];

  int checks = 0;
  int errors = 0;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .cancel(cnc[0]),
    .in_valid(iv[0]), .in_ready(ird[0]), .in_data(idat[0]), .in_exc(iexc[0]), .in_delay(idl[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odat[0]), .out_exc(oexc[0]),
    .out_delay(odl[0]), .occupancy(occ[0])
  );

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .SKID(1)) u_dut1 (
    .clk(clk), .reset(reset), .cancel(cnc[1]),
    .in_valid(iv[1]), .in_ready(ird[1]), .in_data(idat[1]), .in_exc(iexc[1]), .in_delay(idl[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odat[1]), .out_exc(oexc[1]),
    .out_delay(odl[1]), .occupancy(occ[1])
  );

  task automatic chk(input string name, input int d, input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h", name, d, got, exp);
    end
  endtask

  // Reference model: each instance is a FIFO of capacity SKID+1 whose ready rule is
  // "not full" (SKID=1) or "empty or draining this cycle" (SKID=0).
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [BW-1:0] exp_q[$];
    logic armed = 1'b0;
    always @(negedge clk) begin
      logic exp_ready, do_acc, do_pop;
      logic [BW-1:0] exp_head;
      if (g == 1) exp_ready = (exp_q.size() < 2);
      else        exp_ready = (exp_q.size() == 0) || ordy[g];
      exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
      if (armed) begin
        chk("out_valid", g, BW'(ov[g]), BW'(exp_q.size() != 0));
        chk("occupancy", g, BW'(occ[g]), BW'(exp_q.size()));
        chk("in_ready", g, BW'(ird[g]), BW'(exp_ready));
        chk("out_bundle", g, {odat[g], oexc[g], odl[g]}, exp_head);
      end
      do_acc = iv[g] && exp_ready;
      do_pop = (exp_q.size() != 0) && ordy[g];
      if (reset) begin
        exp_q.delete();
        armed = 1'b1;
        free_q[g] = 1'b1;
      end else if (cnc[g]) begin
        exp_q.delete();
        free_q[g] = 1'b1;
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_acc) exp_q.push_back({idat[g], iexc[g], idl[g]});
        free_q[g] = do_acc || !iv[g];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic v, input logic [DATA_W-1:0] data,
                        input logic [EXC_W-1:0] exc, input logic dly, input logic rdy,
                        input logic cn);
    iv[d] = v; idat[d] = data; iexc[d] = exc; idl[d] = dly; ordy[d] = rdy; cnc[d] = cn;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) set_in(d, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rand_cycle(input int v_pct, input int r_pct);
    for (int d = 0; d < 2; d++) begin
      if (!(iv[d] && !free_q[d])) begin
        iv[d]   = ($urandom_range(0, 99) < v_pct);
        idat[d] = {$urandom, $urandom, $urandom, $urandom};
        iexc[d] = EXC_W'($urandom_range(0, 31));
        idl[d]  = 1'($urandom_range(0, 1));
      end
      ordy[d] = ($urandom_range(0, 99) < r_pct);
      cnc[d]  = ($urandom_range(0, 49) == 0);
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    free_q[0] = 1'b1;
    free_q[1] = 1'b1;
    step();

    // reset while a bundle is offered
    for (int d = 0; d < 2; d++) set_in(d, 1'b1, {16{8'hA5}}, 5'h1f, 1'b1, 1'b0, 1'b0);
    step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", d, BW'(ov[d]), '0);
      chk("reset_data", d, BW'(odat[d]), '0);
      chk("reset_occ", d, BW'(occ[d]), '0);
      chk("reset_ready", d, BW'(ird[d]), BW'(1));
    end
    reset = 1'b0;
    idle_all();
    step();

    // streaming through the skid instance
    for (int k = 1; k <= 4; k++) begin
      set_in(1, 1'b1, DATA_W'(k), '0, 1'b0, 1'b1, 1'b0);
      step();
      chk("stream_data", 1, BW'(odat[1]), BW'(k));
      chk("stream_occ", 1, BW'(occ[1]), BW'(1));
    end
    idle_all();
    step();

    // backpressure fills both entries, then drains in order
    set_in(1, 1'b1, 128'h11, '0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1, 1'b1, 128'h22, '0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_occ", 1, BW'(occ[1]), BW'(2));
    chk("bp_ready", 1, BW'(ird[1]), '0);
    chk("bp_head", 1, BW'(odat[1]), BW'(128'h11));
    set_in(1, 1'b1, 128'h33, '0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_head2", 1, BW'(odat[1]), BW'(128'h22));
    chk("bp_occ2", 1, BW'(occ[1]), BW'(1));
    step();
    chk("bp_head3", 1, BW'(odat[1]), BW'(128'h33));
    set_in(1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_occ_end", 1, BW'(occ[1]), '0);

    // flush of a full skid register with an offered bundle
    set_in(1, 1'b1, 128'h44, 5'b10000, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1, 1'b1, 128'h55, 5'b10000, 1'b1, 1'b0, 1'b0);
    step();
    chk("flush_pre_occ", 1, BW'(occ[1]), BW'(2));
    set_in(1, 1'b1, 128'h66, 5'b10000, 1'b1, 1'b0, 1'b1);
    step();
    chk("flush_valid", 1, BW'(ov[1]), '0);
    chk("flush_bundle", 1, {odat[1], oexc[1], odl[1]}, '0);
    chk("flush_occ", 1, BW'(occ[1]), '0);
    idle_all();
    step();

    // single-register instance: combinational ready, replace and bubble
    set_in(0, 1'b1, 128'h77, 5'h3, 1'b0, 1'b0, 1'b0);
    step();
    set_in(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("s0_ready_low", 0, BW'(ird[0]), '0);
    ordy[0] = 1'b1;
    #1;
    chk("s0_ready_high", 0, BW'(ird[0]), BW'(1));
    set_in(0, 1'b1, 128'h88, 5'h4, 1'b1, 1'b1, 1'b0);
    step();
    chk("s0_replace", 0, {odat[0], oexc[0], odl[0]}, {128'h88, 5'h4, 1'b1});
    set_in(0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    chk("s0_bubble", 0, {odat[0], oexc[0], odl[0]}, '0);
    chk("s0_bubble_valid", 0, BW'(ov[0]), '0);

    // random traffic in phases of differing pressure
    for (int i = 0; i < 10000; i++) begin
      case (i / 2500)
        0:       rand_cycle(70, 60);
        1:       rand_cycle(90, 20);
        2:       rand_cycle(30, 90);
        default: rand_cycle(60, 50);
      endcase
    end
    idle_all();
    for (int i = 0; i < 4; i++) step();
    for (int d = 0; d < 2; d++) chk("drain_occ", d, BW'(occ[d]), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
